// File: rtl/div_pkg.sv
// Shared definitions for the div_64_32 restoring divider: FSM state encoding and default width.
package div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then conditionally subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W+1:0] w_shift;
  logic [W:0]   w_sub;
  logic         w_ge;

  // The subtraction only needs W+1 bits because it is used only when the shifted value is >= divisor.
  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {2'b00, i_div});
  assign w_sub   = w_shift[W:0] - {1'b0, i_div};
  assign o_rem   = w_ge ? w_sub : w_shift[W:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/div_64_32.sv
// Sequential 2W/W unsigned restoring divider producing one quotient bit per cycle.
// Optional feature: define DIV_OVERFLOW_CHECK_EN to flag divide-by-zero/overflow at start and skip iteration.
module div_64_32
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W);

  div_state_e     r_state;
  div_state_e     w_next;
  logic [W:0]     r_rem;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_div;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_r;
  logic [CW-1:0]  r_cnt;
  logic [W:0]     w_rem_next;
  logic           w_qbit;
  logic           w_cnt_last;
  logic           w_start_err;

`ifdef DIV_OVERFLOW_CHECK_EN
  logic r_err;
  assign w_start_err = (b == '0) || (a[2*W-1:W] >= b);
  assign err         = r_err;
`else
  assign w_start_err = 1'b0;
  assign err         = 1'b0;
`endif

  assign w_cnt_last = (r_cnt == LAST_CNT);

  div_step #(.W(W)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_lo[W-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = w_start_err ? DONE : CALC;
      CALC:       if (w_cnt_last) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == CALC);
    done = (r_state == DONE);
    q    = r_q;
    r    = r_r;
  end

  // CALC spends W cycles iterating and one more cycle publishing, so outputs never show partial results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem <= '0;
      r_lo  <= '0;
      r_div <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
`ifdef DIV_OVERFLOW_CHECK_EN
      r_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_rem <= {1'b0, a[2*W-1:W]};
            r_lo  <= a[W-1:0];
            r_div <= b;
            r_quo <= '0;
            r_cnt <= '0;
`ifdef DIV_OVERFLOW_CHECK_EN
            if (w_start_err) begin
              r_q   <= '1;
              r_r   <= a[W-1:0];
              r_err <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          if (w_cnt_last) begin
            r_q <= r_quo;
            r_r <= r_rem[W-1:0];
`ifdef DIV_OVERFLOW_CHECK_EN
            r_err <= 1'b0;
`endif
          end else begin
            r_rem <= w_rem_next;
            r_lo  <= {r_lo[W-2:0], 1'b0};
            r_quo <= {r_quo[W-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_64_32.sv
// Scoreboard testbench for div_64_32: expected results queued at start, checked when done rises.
// Honours DIV_OVERFLOW_CHECK_EN for the divide-by-zero expectation.
module tb_div_64_32;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
    bit           chkData;
  } expect_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           err;

  expect_t sbQueue[$];
  int      nChecks = 0;
  int      nPass   = 0;

  div_64_32 #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counts stay consistent.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic startOp(input logic [2*W-1:0] aIn, input logic [W-1:0] bIn);
    start = 1'b1;
    a     = aIn;
    b     = bIn;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
  endtask

  // Reference model: errors resolve on the accepting edge itself, valid results W+1 edges later.
  task automatic applyStimulus(input logic [2*W-1:0] aIn, input logic [W-1:0] bIn);
    expect_t e;
    e.err     = 1'b0;
    e.lat     = W + 1;
    e.chkData = 1'b1;
    if (bIn == '0 || aIn[2*W-1:W] >= bIn) begin
`ifdef DIV_OVERFLOW_CHECK_EN
      e.err = 1'b1;
      e.lat = 0;
      e.q   = '1;
      e.r   = aIn[W-1:0];
`else
      e.chkData = 1'b0;
      e.q       = '0;
      e.r       = '0;
`endif
    end else begin
      e.q = W'(aIn / {32'd0, bIn});
      e.r = W'(aIn % {32'd0, bIn});
    end
    sbQueue.push_back(e);
    startOp(aIn, bIn);
  endtask

  // Wait (bounded) for done, optionally re-pulsing start with junk operands mid-flight.
  task automatic waitForResult(input string tag, input int disturbAt);
    expect_t e;
    int      cycles;
    cycles = 0;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 1, 0);
      return;
    end
    while (!done && cycles < 100) begin
      if (cycles == 0 && sbQueue[0].lat > 0) begin
        checkOutput({tag, "_busyRun"}, busy, 1'b1);
      end
      if (disturbAt > 0 && cycles == disturbAt) begin
        start = 1'b1;
        a     = {$urandom(), $urandom()};
        b     = $urandom();
      end
      if (disturbAt > 0 && cycles == disturbAt + 1) start = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    e = sbQueue.pop_front();
    checkOutput({tag, "_latency"}, cycles, e.lat);
    if (!done) return;
    checkOutput({tag, "_busyDone"}, busy, 1'b0);
    checkOutput({tag, "_err"}, err, e.err);
    if (e.chkData) begin
      checkOutput({tag, "_q"}, q, e.q);
      checkOutput({tag, "_r"}, r, e.r);
    end
  endtask

  initial begin
    logic [W-1:0]   rb;
    logic [2*W-1:0] ra;
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_q", q, 0);
    checkOutput("rst_r", r, 0);
    checkOutput("rst_err", err, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(64'd100, 32'd7);
    waitForResult("basic", 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_done", done, 1'b1);
    checkOutput("hold_q", q, 32'd14);
    checkOutput("hold_r", r, 32'd2);

    applyStimulus(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    waitForResult("maxq", 0);

    applyStimulus(64'h0000_0005_1234_5678, 32'd0);
    waitForResult("divzero", 0);

    applyStimulus(64'h0000_0003_DEAD_BEEF, 32'h1234_5679);
    waitForResult("ignore", 10);

    for (int i = 0; i < 4; i++) begin
      rb = $urandom() | 32'h1;
      ra = {W'($urandom() % rb), W'($urandom())};
      applyStimulus(ra, rb);
      waitForResult("rand", 0);
    end

    // Abort mid-CALC: no expectation is queued for the lost operation.
    startOp(64'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_q", q, 0);
    checkOutput("abort_r", r, 0);
    checkOutput("abort_err", err, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort_noDone", done, 1'b0);

    applyStimulus(64'd9, 32'd3);
    waitForResult("postReset", 0);

    applyStimulus(64'd50, 32'd8);
    waitForResult("backToBack", 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/div_64_32.md
DIV_64_32 -- requirements
Module: div_64_32

Interface
REQ-001 SHALL have parameter `W`, default 32: divisor, quotient and remainder width; dividend is 2*W.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-low reset, sampled on rising `clk`.
REQ-004 SHALL have port `start`, input, 1 bit: request a new division; operands are sampled on the same edge.
REQ-005 SHALL have port `a`, input, 2*W bits: unsigned dividend.
REQ-006 SHALL have port `b`, input, W bits: unsigned divisor.
REQ-007 SHALL have port `busy`, output, 1 bit: high while an iteration is in progress.
REQ-008 SHALL have port `done`, output, 1 bit: high while `q`/`r`/`err` hold a valid result.
REQ-009 SHALL have port `q`, output, W bits: quotient.
REQ-010 SHALL have port `r`, output, W bits: remainder.
REQ-011 SHALL have port `err`, output, 1 bit: divide-by-zero or quotient overflow.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
- IDLE -> CALC on `start`.
- CALC -> DONE after W iterations.
- DONE -> CALC on `start`; otherwise DONE holds.
REQ-013 SHALL latch `a` and `b` internally when `start` is accepted; operand changes after that edge SHALL have no effect.
REQ-014 SHALL use restoring division.
- Partial remainder is W+1 bits, initialised to `a[2W-1:W]`.
- Each CALC cycle shifts in the next dividend bit, MSB-first from `a[W-1:0]`.
- Subtract `b` when the partial remainder is >= `b`.
- Shift the comparison result into the quotient LSB.
REQ-015 SHALL assert `done` exactly W+1 rising edges after the edge that accepted `start` (33 cycles for W=32) when no error is detected.
REQ-016 SHALL hold `done` high, with `q`, `r` and `err` stable, until the next accepted `start` or reset.
REQ-017 SHALL drive `busy`=1 exactly while in CALC; `busy` and `done` SHALL never be high together.
REQ-018 SHALL ignore `start` while in CALC, with no restart and no change to the latched operands.
REQ-019 SHALL, on `start` in DONE, deassert `done` on the next edge and begin the new operation with identical latency.
REQ-020 SHALL, for valid inputs (`a[2W-1:W]` < `b`), satisfy `a` == `q`*`b` + `r` with `r` < `b`.
REQ-021 SHALL keep `q` and `r` at their last values while in IDLE or CALC; intermediate values SHALL NOT appear on the outputs.

Reset
REQ-022 SHALL, when `reset`=0 at a rising edge, force state IDLE with `busy`=0, `done`=0, `q`=0, `r`=0 and `err`=0.
REQ-023 SHALL abort any in-flight operation on reset mid-CALC, without asserting `done`.
REQ-024 SHALL give reset priority over a simultaneous `start`.

Configuration
REQ-025 SHALL, with `DIV_OVERFLOW_CHECK_EN` defined, evaluate errors at `start`.
- If `b`==0 or `a[2W-1:W]` >= `b`, skip CALC.
- Assert `done`=1 with `err`=1, `q`=all-ones and `r`=`a[W-1:0]` on the next edge (latency 1).
REQ-026 SHALL, without `DIV_OVERFLOW_CHECK_EN`, tie `err` to 0 and always run W iterations; results for invalid inputs are unspecified but `done` timing is unchanged.

Structure
REQ-027 SHALL place the FSM state enum and the default width constant in shared package `div_pkg`.
REQ-028 SHALL implement one restoring iteration (compare, subtract, next quotient bit) as combinational sub-module `div_step`, instantiated once.

Verification
REQ-029 SHALL cover these directed scenarios (W=32):
- `a`=100, `b`=7, `start` pulse -> `done` after 33 cycles, `q`=14, `r`=2, `err`=0.
- `a`=0xFFFF_FFFE_0000_0001, `b`=0xFFFF_FFFF -> `q`=0xFFFF_FFFF, `r`=0.
- `b`=0 with `DIV_OVERFLOW_CHECK_EN` -> `done`=1 and `err`=1 one cycle after `start`, `q`=0xFFFF_FFFF. Without the macro -> `err`=0 and `done` at 33 cycles.
- `start` re-pulsed and `a`/`b` changed at cycle 10 of CALC -> ignored; original result returned at cycle 33.
- `reset`=0 at cycle 5 of CALC -> next cycle all outputs are 0 and `busy`=0; a subsequent `a`=9, `b`=3 -> `q`=3, `r`=0.
- Back-to-back: `start` in DONE with `a`=50, `b`=8 -> `done` drops next cycle, rises 33 cycles later with `q`=6, `r`=2.
